// File: rtl/mem_pkg.sv
// Shared memory-side types for the 32x64 one-read/one-write synchronous-read memory
// and its burst reader client.
package mem_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 64;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } burst_state_t;

endpackage

// File: rtl/mem_rsp_fifo2.sv
// Two-entry data+last FIFO that buffers memory read returns ahead of the
// response stream. The caller guarantees no push while full and no pop while empty.
module mem_rsp_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic [1:0]             last_q, last_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = data_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read client: issues sequential reads, absorbs the one-cycle read latency and
// streams words out with valid/ready/last. Optional macro MEM_BURST_READER_STATS_EN adds stall_cycles.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   start_len,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              done
`ifdef MEM_BURST_READER_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  burst_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [1:0] fifo_count;
  logic [2:0] occ_after;
  logic       pop;
  logic       issue;
  logic       start_fire;

  assign start_fire = start_valid && (state_q == IDLE);
  assign rsp_valid  = (fifo_count != 2'd0);
  assign pop        = rsp_valid && rsp_ready;

  // Words buffered plus the one possibly in flight, after this cycle's pop; keeping
  // this below 2 is what guarantees the 2-entry FIFO never overflows.
  assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (remaining_q != '0) && (occ_after < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == (ADDR_W+1)'(1));

    case (state_q)
      IDLE: begin
        if (start_fire) begin
          addr_d      = start_addr;
          remaining_d = start_len;
          state_d     = (start_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (remaining_q == (ADDR_W+1)'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish in the cycle the final buffered word is handed off.
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d      = addr_q + ADDR_W'(1);
      remaining_d = remaining_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  mem_rsp_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(mem_rdata),
    .push_last(inflight_last_q),
    .pop      (pop),
    .head_data(rsp_data),
    .head_last(rsp_last),
    .count    (fifo_count)
  );

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign mem_raddr   = addr_q;
  assign mem_ren     = issue;

`ifdef MEM_BURST_READER_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_fire) begin
      stall_d = 16'd0;
    end else if (rsp_valid && !rsp_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader with a write-first synchronous-read memory model.
module tb_mem_burst_reader;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   start_len;
  logic [AW-1:0] mem_raddr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          done;
`ifdef MEM_BURST_READER_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_mem [32];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_burst_reader dut (
    .clock      (clock),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .start_addr (start_addr),
    .start_len  (start_len),
    .mem_raddr  (mem_raddr),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .done       (done)
`ifdef MEM_BURST_READER_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Memory reads every cycle; a same-address write on the same edge is returned.
  always @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= (mem_we && (mem_waddr == mem_raddr)) ? mem_wdata : mem[mem_raddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: rsp_ready always high; mode 1: low in cycles 4-9, then high on even cycles.
  task automatic run_burst(input logic [4:0] a, input logic [5:0] n, input int mode,
                           input bit wf, output logic [63:0] first_w, output logic [63:0] last_w);
    int issued = 0;
    int popped = 0;
    int stalls = 0;
    int first_cyc = -1;
    int last_pop = -1;
    int done_cyc = -1;
    int c = 1;
    bit prev_stall = 0;
    bit pop_now;
    logic [63:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [4:0] ea;
    first_w = '0;
    last_w  = '0;
    @(negedge clock);
    start_valid = 1'b1;
    start_addr  = a;
    start_len   = n;
    rsp_ready   = 1'b1;
    check("start_ready_idle", {63'd0, start_ready}, 64'd1);
    @(posedge clock);
    #1 start_valid = 1'b0;
    if (wf) begin
      mem_we    = 1'b1;
      mem_waddr = a;
      mem_wdata = 64'hDEAD;
      exp_mem[a] = 64'hDEAD;
    end
    while (c <= 200) begin
      if (mode == 1 && c >= 4 && c <= 9) rsp_ready = 1'b0;
      else if (mode == 1 && c > 9)       rsp_ready = (c % 2 == 0);
      else                               rsp_ready = 1'b1;
      @(negedge clock);
      pop_now = rsp_valid && rsp_ready;
      if (mem_ren) begin
        ea = a + 5'(issued);
        check("raddr", {59'd0, mem_raddr}, {59'd0, ea});
        check("issue_occupancy", {63'd0, (issued - popped - int'(pop_now)) < 2}, 64'd1);
        if (issued == 0) check("first_issue_cycle", 64'(c), 64'd1);
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", {63'd0, rsp_valid}, 64'd1);
        check("stall_data", rsp_data, prev_data);
        check("stall_last", {63'd0, rsp_last}, {63'd0, prev_last});
      end
      if (rsp_valid && first_cyc < 0) begin
        first_cyc = c;
        check("first_valid_cycle", 64'(c), 64'd3);
      end
      if (pop_now) begin
        ea = a + 5'(popped);
        check("data", rsp_data, exp_mem[ea]);
        check("last", {63'd0, rsp_last}, {63'd0, popped == int'(n) - 1});
        if (popped == 0) first_w = rsp_data;
        last_w = rsp_data;
        if (popped == int'(n) - 1) last_pop = c;
        popped++;
      end
      if (rsp_valid && !rsp_ready) stalls++;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_last  = rsp_last;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clock);
      #1;
      if (c == 1) mem_we = 1'b0;
      c++;
    end
    mem_we = 1'b0;
    if (done_cyc < 0) check("burst_timeout", 64'd0, 64'd1);
    check("issued_count", 64'(issued), 64'(n));
    check("popped_count", 64'(popped), 64'(n));
    check("done_after_last", 64'(done_cyc), 64'(last_pop + 1));
`ifdef MEM_BURST_READER_STATS_EN
    check("stall_cycles", {48'd0, stall_cycles}, 64'(stalls));
`endif
    @(negedge clock);
    check("idle_after_done", {62'd0, start_ready, done}, {62'd0, 1'b1, 1'b0});
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [5:0]  len;
    int          mode;
    bit          wf;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] fw, lw;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 64'(i) * 64'h1111;
      exp_mem[i] = 64'(i) * 64'h1111;
    end
    reset       = 1'b1;
    start_valid = 1'b0;
    start_addr  = '0;
    start_len   = '0;
    rsp_ready   = 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    repeat (2) @(negedge clock);
    check("reset_outputs",
          {57'd0, start_ready, rsp_valid, rsp_last, mem_ren, busy, done, 1'b0},
          {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_raddr", {59'd0, mem_raddr}, 64'd0);
`ifdef MEM_BURST_READER_STATS_EN
    check("reset_stall_cycles", {48'd0, stall_cycles}, 64'd0);
`endif
    reset = 1'b0;

    vecs[0] = '{5'd3,  6'd4,  0, 1'b0, 64'h3333,  64'h6666};
    vecs[1] = '{5'd30, 6'd4,  0, 1'b0, 64'h1FFFE, 64'h1111};
    vecs[2] = '{5'd0,  6'd32, 0, 1'b0, 64'h0,     64'h2110F};
    vecs[3] = '{5'd5,  6'd8,  1, 1'b0, 64'h5555,  64'hCCCC};
    vecs[4] = '{5'd7,  6'd1,  0, 1'b1, 64'hDEAD,  64'hDEAD};

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].wf, fw, lw);
      check($sformatf("vec%0d_first_word", i), fw, vecs[i].exp_first);
      check($sformatf("vec%0d_last_word", i), lw, vecs[i].exp_last);
      $display("[TB] burst addr=%0d len=%0d mode=%0d first=%h last=%h",
               vecs[i].addr, vecs[i].len, vecs[i].mode, fw, lw);
    end

    // Zero-length burst: straight to DONE, nothing issued or returned.
    @(negedge clock);
    start_valid = 1'b1;
    start_addr  = 5'd9;
    start_len   = 6'd0;
    @(posedge clock);
    #1 start_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      check("zero_len_no_valid", {63'd0, rsp_valid}, 64'd0);
      check("zero_len_no_ren", {63'd0, mem_ren}, 64'd0);
      check("zero_len_done", {63'd0, done}, {63'd0, c == 1});
      check("zero_len_start_ready", {63'd0, start_ready}, {63'd0, c != 1});
      @(posedge clock);
      #1;
    end
    $display("[TB] zero-length burst checked");

    // Asynchronous reset in cycle 5 of a 16-word burst.
    @(negedge clock);
    start_valid = 1'b1;
    start_addr  = 5'd0;
    start_len   = 6'd16;
    rsp_ready   = 1'b1;
    @(posedge clock);
    #1 start_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    check("pre_reset_busy_valid", {62'd0, busy, rsp_valid}, {62'd0, 1'b1, 1'b1});
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {57'd0, start_ready, rsp_valid, rsp_last, mem_ren, busy, done, 1'b0},
          {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_reset_raddr", {59'd0, mem_raddr}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("post_reset_quiet", {62'd0, rsp_valid, busy}, 64'd0);
    end
    run_burst(5'd10, 6'd2, 0, 1'b0, fw, lw);
    check("post_reset_first", fw, 64'hAAAA);
    check("post_reset_last", lw, 64'hBBBB);
    $display("[TB] reset mid-burst then len=2 burst first=%h last=%h", fw, lw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
